// File: rtl/mem_req_arbiter.sv
// Two-requester (fetch, load/store) arbiter in front of a single-outstanding MMU port.
// Round-robin on ties, registered grant/request pulses, per-transaction wait timeout.
module mem_req_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        dig_clk,
    input  logic        rstn,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,

    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [2:0]  ls_func3,
    output logic        ls_gnt,
    output logic        ls_valid,
    output logic [31:0] ls_rdata,

    output logic        mmu_rd_req,
    output logic [31:0] mmu_rd_addr,
    output logic [2:0]  mmu_rd_func3,
    input  logic        mmu_rd_valid,
    input  logic [31:0] mmu_rd_data,

    output logic        mmu_wr_req,
    output logic [31:0] mmu_wr_addr,
    output logic [31:0] mmu_wr_data,
    output logic [2:0]  mmu_wr_func3,
    input  logic        mmu_wr_done,

    output logic        timeout_err
);

    typedef enum logic [1:0] {StIdle, StRdWait, StWrWait} state_e;

    // Counter holds completed wait cycles; the last permitted one is TIMEOUT-1.
    localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);
    localparam logic [2:0] WordFunc3 = 3'b010;

    state_e     state_q;
    logic       last_ls_q;
    logic       owner_ls_q;
    logic [7:0] wait_cnt_q;
    logic       pick_ls;

    // LS wins when alone, or on a tie when IF was granted last.
    assign pick_ls = ls_req && (!if_req || !last_ls_q);

    always_ff @(posedge dig_clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            last_ls_q    <= 1'b0;
            owner_ls_q   <= 1'b0;
            wait_cnt_q   <= '0;
            if_gnt       <= 1'b0;
            if_valid     <= 1'b0;
            if_rdata     <= '0;
            ls_gnt       <= 1'b0;
            ls_valid     <= 1'b0;
            ls_rdata     <= '0;
            mmu_rd_req   <= 1'b0;
            mmu_rd_addr  <= '0;
            mmu_rd_func3 <= '0;
            mmu_wr_req   <= 1'b0;
            mmu_wr_addr  <= '0;
            mmu_wr_data  <= '0;
            mmu_wr_func3 <= '0;
            timeout_err  <= 1'b0;
        end else begin
            if_gnt     <= 1'b0;
            ls_gnt     <= 1'b0;
            if_valid   <= 1'b0;
            ls_valid   <= 1'b0;
            mmu_rd_req <= 1'b0;
            mmu_wr_req <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (if_req || ls_req) begin
                        wait_cnt_q <= '0;
                        last_ls_q  <= pick_ls;
                        owner_ls_q <= pick_ls;
                        if (pick_ls) begin
                            ls_gnt <= 1'b1;
                            if (ls_we) begin
                                mmu_wr_req   <= 1'b1;
                                mmu_wr_addr  <= ls_addr;
                                mmu_wr_data  <= ls_wdata;
                                mmu_wr_func3 <= ls_func3;
                                state_q      <= StWrWait;
                            end else begin
                                mmu_rd_req   <= 1'b1;
                                mmu_rd_addr  <= ls_addr;
                                mmu_rd_func3 <= ls_func3;
                                state_q      <= StRdWait;
                            end
                        end else begin
                            if_gnt       <= 1'b1;
                            mmu_rd_req   <= 1'b1;
                            mmu_rd_addr  <= if_addr;
                            mmu_rd_func3 <= WordFunc3;
                            state_q      <= StRdWait;
                        end
                    end
                end

                StRdWait: begin
                    // A response arriving on the timeout cycle still wins.
                    if (mmu_rd_valid) begin
                        if (owner_ls_q) begin
                            ls_valid <= 1'b1;
                            ls_rdata <= mmu_rd_data;
                        end else begin
                            if_valid <= 1'b1;
                            if_rdata <= mmu_rd_data;
                        end
                        state_q <= StIdle;
                    end else if (wait_cnt_q == TmoLast) begin
                        if (owner_ls_q) begin
                            ls_valid <= 1'b1;
                            ls_rdata <= '0;
                        end else begin
                            if_valid <= 1'b1;
                            if_rdata <= '0;
                        end
                        timeout_err <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end

                StWrWait: begin
                    if (mmu_wr_done) begin
                        ls_valid <= 1'b1;
                        ls_rdata <= '0;
                        state_q  <= StIdle;
                    end else if (wait_cnt_q == TmoLast) begin
                        ls_valid    <= 1'b1;
                        ls_rdata    <= '0;
                        timeout_err <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: stimulus pushes expected grants/responses,
// an independent monitor pops and compares them as the DUT presents pulses.
module tb_mem_req_arbiter;

    localparam int unsigned TMO = 8;
    localparam int unsigned NO_RESP = 255;

    logic        dig_clk;
    logic        rstn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [2:0]  ls_func3;
    logic        ls_gnt;
    logic        ls_valid;
    logic [31:0] ls_rdata;
    logic        mmu_rd_req;
    logic [31:0] mmu_rd_addr;
    logic [2:0]  mmu_rd_func3;
    logic        mmu_rd_valid;
    logic [31:0] mmu_rd_data;
    logic        mmu_wr_req;
    logic [31:0] mmu_wr_addr;
    logic [31:0] mmu_wr_data;
    logic [2:0]  mmu_wr_func3;
    logic        mmu_wr_done;
    logic        timeout_err;

    mem_req_arbiter #(.TIMEOUT(TMO)) dut (
        .dig_clk      (dig_clk),
        .rstn         (rstn),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_valid     (if_valid),
        .if_rdata     (if_rdata),
        .ls_req       (ls_req),
        .ls_we        (ls_we),
        .ls_addr      (ls_addr),
        .ls_wdata     (ls_wdata),
        .ls_func3     (ls_func3),
        .ls_gnt       (ls_gnt),
        .ls_valid     (ls_valid),
        .ls_rdata     (ls_rdata),
        .mmu_rd_req   (mmu_rd_req),
        .mmu_rd_addr  (mmu_rd_addr),
        .mmu_rd_func3 (mmu_rd_func3),
        .mmu_rd_valid (mmu_rd_valid),
        .mmu_rd_data  (mmu_rd_data),
        .mmu_wr_req   (mmu_wr_req),
        .mmu_wr_addr  (mmu_wr_addr),
        .mmu_wr_data  (mmu_wr_data),
        .mmu_wr_func3 (mmu_wr_func3),
        .mmu_wr_done  (mmu_wr_done),
        .timeout_err  (timeout_err)
    );

    typedef struct {
        bit          is_ls;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  func3;
        int unsigned lat;    // cycles from mmu request to response; >= TMO means never
        logic [31:0] data;
    } txn_t;

    typedef struct {
        bit          is_ls;
        bit          we;
        logic [31:0] addr;
        logic [31:0] rdata;
        bit          tmo;
        int unsigned delay;  // cycles from grant pulse to valid pulse
    } resp_t;

    txn_t  gnt_q[$];
    txn_t  mmu_q[$];
    resp_t resp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit m_last_ls = 1'b0;
    bit m_tmo = 1'b0;
    bit spur_rd = 1'b0;
    bit spur_wr = 1'b0;
    txn_t none_t;

    initial begin
        dig_clk = 1'b0;
        forever #5 dig_clk = ~dig_clk;
    end

    always @(posedge dig_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit outs_nonzero();
        return |{if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata, mmu_rd_req,
                 mmu_rd_addr, mmu_rd_func3, mmu_wr_req, mmu_wr_addr, mmu_wr_data,
                 mmu_wr_func3, timeout_err};
    endfunction

    // Monitor: compares every grant and every valid pulse against the scoreboard.
    txn_t  mon_g;
    resp_t mon_r;
    int    gnt_cyc = 0;
    initial begin
        forever begin
            @(negedge dig_clk);
            if (if_gnt || ls_gnt) begin
                if (gnt_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_gnt: if_gnt=%0b ls_gnt=%0b, none expected", if_gnt,
                             ls_gnt);
                end else begin
                    mon_g = gnt_q.pop_front();
                    gnt_cyc = cyc;
                    chk("gnt_who", 64'({if_gnt, ls_gnt}), 64'(mon_g.is_ls ? 2'b01 : 2'b10));
                    chk("mmu_req_kind", 64'({mmu_rd_req, mmu_wr_req}),
                        64'(mon_g.we ? 2'b01 : 2'b10));
                    if (mon_g.we) begin
                        chk("mmu_wr_addr", 64'(mmu_wr_addr), 64'(mon_g.addr));
                        chk("mmu_wr_data", 64'(mmu_wr_data), 64'(mon_g.wdata));
                        chk("mmu_wr_func3", 64'(mmu_wr_func3), 64'(mon_g.func3));
                    end else begin
                        chk("mmu_rd_addr", 64'(mmu_rd_addr), 64'(mon_g.addr));
                        chk("mmu_rd_func3", 64'(mmu_rd_func3), 64'(mon_g.func3));
                    end
                end
            end else if (mmu_rd_req || mmu_wr_req) begin
                checks++;
                errors++;
                $display("FAIL unexpected_mmu_req: rd=%0b wr=%0b without grant", mmu_rd_req,
                         mmu_wr_req);
            end
            if (if_valid || ls_valid) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: if_valid=%0b ls_valid=%0b, none expected",
                             if_valid, ls_valid);
                end else begin
                    mon_r = resp_q.pop_front();
                    chk("valid_who", 64'({if_valid, ls_valid}), 64'(mon_r.is_ls ? 2'b01 : 2'b10));
                    chk("rdata", 64'(mon_r.is_ls ? ls_rdata : if_rdata), 64'(mon_r.rdata));
                    chk("resp_delay", 64'(cyc - gnt_cyc), 64'(mon_r.delay));
                    chk("timeout_err", 64'(timeout_err), 64'(mon_r.tmo));
                    chk("addr_held", 64'(mon_r.we ? mmu_wr_addr : mmu_rd_addr), 64'(mon_r.addr));
                end
            end
        end
    end

    // MMU model: replies to each request after the latency the stimulus chose.
    txn_t        mmu_t;
    bit          pend_on = 1'b0;
    bit          pend_wr = 1'b0;
    int unsigned pend_cnt = 0;
    logic [31:0] pend_data = '0;

    task automatic fire(input bit wr, input logic [31:0] d);
        if (wr) begin
            mmu_wr_done = 1'b1;
        end else begin
            mmu_rd_valid = 1'b1;
            mmu_rd_data  = d;
        end
    endtask

    initial begin
        mmu_rd_valid = 1'b0;
        mmu_wr_done  = 1'b0;
        mmu_rd_data  = '0;
        forever begin
            @(negedge dig_clk);
            mmu_rd_valid = 1'b0;
            mmu_wr_done  = 1'b0;
            mmu_rd_data  = $urandom();
            if (pend_on) begin
                if (pend_cnt == 0) begin
                    fire(pend_wr, pend_data);
                    pend_on = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if ((mmu_rd_req || mmu_wr_req) && mmu_q.size() > 0) begin
                mmu_t = mmu_q.pop_front();
                if (mmu_t.lat < TMO) begin
                    if (mmu_t.lat == 0) begin
                        fire(mmu_t.we, mmu_t.data);
                    end else begin
                        pend_on   = 1'b1;
                        pend_wr   = mmu_t.we;
                        pend_cnt  = mmu_t.lat - 1;
                        pend_data = mmu_t.data;
                    end
                end
            end
            if (spur_rd) begin
                mmu_rd_valid = 1'b1;
                spur_rd = 1'b0;
            end
            if (spur_wr) begin
                mmu_wr_done = 1'b1;
                spur_wr = 1'b0;
            end
        end
    end

    function automatic txn_t mk(input bit is_ls, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [2:0] func3,
                                input int unsigned lat, input logic [31:0] data);
        txn_t t;
        t.is_ls = is_ls;
        t.we    = we;
        t.addr  = addr;
        t.wdata = wdata;
        t.func3 = func3;
        t.lat   = lat;
        t.data  = data;
        return t;
    endfunction

    function automatic txn_t rand_txn(input bit is_ls);
        bit we;
        we = is_ls ? 1'($urandom_range(0, 1)) : 1'b0;
        return mk(is_ls, we, $urandom() & 32'hFFFF_FFFC, $urandom(),
                  is_ls ? 3'($urandom_range(0, 7)) : 3'b010, $urandom_range(0, TMO + 2),
                  $urandom());
    endfunction

    // Reference model: fixes grant order and response content, then drives the requests.
    task automatic scenario(input bit use_if, input bit use_ls, input txn_t ti, input txn_t tl,
                            input bit spur);
        txn_t  order[$];
        resp_t r;
        bit    ls_first;
        bit    gi;
        bit    gl;
        bit    done;
        ls_first = use_ls && (!use_if || !m_last_ls);
        if (ls_first) begin
            order.push_back(tl);
            if (use_if) order.push_back(ti);
        end else begin
            order.push_back(ti);
            if (use_ls) order.push_back(tl);
        end
        foreach (order[i]) begin
            gnt_q.push_back(order[i]);
            mmu_q.push_back(order[i]);
            r.is_ls = order[i].is_ls;
            r.we    = order[i].we;
            r.addr  = order[i].addr;
            if (order[i].lat < TMO) begin
                r.rdata = order[i].we ? 32'h0 : order[i].data;
                r.delay = order[i].lat + 1;
            end else begin
                r.rdata = 32'h0;
                r.delay = TMO;
                m_tmo   = 1'b1;
            end
            r.tmo = m_tmo;
            resp_q.push_back(r);
            m_last_ls = order[i].is_ls;
        end
        @(posedge dig_clk);
        #1;
        if (use_if) begin
            if_req  = 1'b1;
            if_addr = ti.addr;
        end
        if (use_ls) begin
            ls_req   = 1'b1;
            ls_we    = tl.we;
            ls_addr  = tl.addr;
            ls_wdata = tl.wdata;
            ls_func3 = tl.func3;
        end
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge dig_clk);
            gi = if_gnt;
            gl = ls_gnt;
            @(posedge dig_clk);
            #1;
            if (gi) if_req = 1'b0;
            if (gl) begin
                ls_req = 1'b0;
                if (spur) spur_rd = 1'b1;
            end
            done = !if_req && !ls_req && gnt_q.size() == 0 && resp_q.size() == 0;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL scenario_bound: gnt_pending=%0d resp_pending=%0d expected 0",
                     gnt_q.size(), resp_q.size());
            gnt_q.delete();
            resp_q.delete();
            mmu_q.delete();
            if_req = 1'b0;
            ls_req = 1'b0;
        end
    endtask

    initial begin
        bit seen;
        none_t = mk(1'b0, 1'b0, 32'h0, 32'h0, 3'b0, 0, 32'h0);
        rstn = 1'b0;
        if_req = 1'b0;
        if_addr = '0;
        ls_req = 1'b0;
        ls_we = 1'b0;
        ls_addr = '0;
        ls_wdata = '0;
        ls_func3 = '0;
        repeat (3) @(posedge dig_clk);
        #1;
        chk("reset_outputs_zero", 64'(outs_nonzero()), 64'(0));
        rstn = 1'b1;
        repeat (2) @(posedge dig_clk);
        #1;
        chk("idle_outputs_zero", 64'(outs_nonzero()), 64'(0));

        // Fetch read with a 3-cycle MMU latency.
        scenario(1'b1, 1'b0, mk(1'b0, 1'b0, 32'h100, 32'h0, 3'b010, 3, 32'hCAFE_0001), none_t,
                 1'b0);
        // Simultaneous requests twice: LS, IF, LS, IF.
        repeat (2) begin
            scenario(1'b1, 1'b1, mk(1'b0, 1'b0, 32'h1000, 32'h0, 3'b010, 2, 32'hAAAA_0001),
                     mk(1'b1, 1'b0, 32'h2000, 32'h0, 3'b100, 1, 32'hBBBB_0002), 1'b0);
        end
        // Store.
        scenario(1'b0, 1'b1, none_t, mk(1'b1, 1'b1, 32'h200, 32'h1234_5678, 3'b010, 2, 32'h0),
                 1'b0);
        // Response on the same cycle the timeout would fire: response wins.
        scenario(1'b0, 1'b1, none_t, mk(1'b1, 1'b0, 32'h300, 32'h0, 3'b001, TMO - 1,
                                        32'h5555_AAAA), 1'b0);
        // Stray MMU responses in IDLE, then a stray read-valid during WR_WAIT.
        @(posedge dig_clk);
        #1;
        spur_rd = 1'b1;
        spur_wr = 1'b1;
        repeat (4) @(posedge dig_clk);
        scenario(1'b0, 1'b1, none_t, mk(1'b1, 1'b1, 32'h400, 32'h0BAD_F00D, 3'b000, 6, 32'h0),
                 1'b1);
        // Timeout on a fetch, then the flag stays set.
        scenario(1'b1, 1'b0, mk(1'b0, 1'b0, 32'h500, 32'h0, 3'b010, NO_RESP, 32'h0), none_t,
                 1'b0);
        scenario(1'b1, 1'b0, mk(1'b0, 1'b0, 32'h504, 32'h0, 3'b010, 1, 32'h7777_0000), none_t,
                 1'b0);

        // Reset while a fetch waits; the late MMU response must be ignored.
        gnt_q.push_back(mk(1'b0, 1'b0, 32'h600, 32'h0, 3'b010, 4, 32'hDEAD_BEEF));
        mmu_q.push_back(mk(1'b0, 1'b0, 32'h600, 32'h0, 3'b010, 4, 32'hDEAD_BEEF));
        @(posedge dig_clk);
        #1;
        if_req  = 1'b1;
        if_addr = 32'h600;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge dig_clk);
            seen = if_gnt;
        end
        chk("rst_test_gnt_seen", 64'(seen), 64'(1));
        @(posedge dig_clk);
        #1;
        if_req = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("async_reset_outputs_zero", 64'(outs_nonzero()), 64'(0));
        m_tmo = 1'b0;
        m_last_ls = 1'b0;
        repeat (2) @(negedge dig_clk);
        #1;
        rstn = 1'b1;
        repeat (6) @(posedge dig_clk);
        #1;
        chk("post_reset_outputs_zero", 64'(outs_nonzero()), 64'(0));
        chk("post_reset_pending_gnt", 64'(gnt_q.size()), 64'(0));

        // After reset the tie goes to LS again.
        scenario(1'b1, 1'b1, mk(1'b0, 1'b0, 32'h700, 32'h0, 3'b010, 0, 32'h1111_2222),
                 mk(1'b1, 1'b1, 32'h800, 32'h3333_4444, 3'b101, 0, 32'h0), 1'b0);

        for (int n = 0; n < 40; n++) begin
            int unsigned kind;
            kind = $urandom_range(0, 2);
            scenario(kind != 1, kind != 0, rand_txn(1'b0), rand_txn(1'b1), 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge dig_clk);
        end

        repeat (5) @(posedge dig_clk);
        #1;
        chk("final_gnt_queue_empty", 64'(gnt_q.size()), 64'(0));
        chk("final_resp_queue_empty", 64'(resp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, wait-state cycle limit (1..255, 8-bit counter).
REQ-002 SHALL have port: dig_clk  in  1  clock, all state on rising edge.
REQ-003 SHALL have port: rstn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: if_req  in  1  fetch read request, level, held until if_gnt.
REQ-005 SHALL have port: if_addr  in  32  fetch address.
REQ-006 SHALL have port: if_gnt  out  1  fetch accept pulse.
REQ-007 SHALL have port: if_valid  out  1  fetch response pulse.
REQ-008 SHALL have port: if_rdata  out  32  fetch read data.
REQ-009 SHALL have port: ls_req  in  1  load/store request, level, held until ls_gnt.
REQ-010 SHALL have port: ls_we  in  1  1 = store, 0 = load.
REQ-011 SHALL have port: ls_addr  in  32  load/store address.
REQ-012 SHALL have port: ls_wdata  in  32  store data.
REQ-013 SHALL have port: ls_func3  in  3  access size/sign code.
REQ-014 SHALL have port: ls_gnt  out  1  load/store accept pulse.
REQ-015 SHALL have port: ls_valid  out  1  load data or store completion pulse.
REQ-016 SHALL have port: ls_rdata  out  32  load data (0 for stores).
REQ-017 SHALL have port: mmu_rd_req  out  1  MMU read request pulse.
REQ-018 SHALL have port: mmu_rd_addr  out  32  MMU read address.
REQ-019 SHALL have port: mmu_rd_func3  out  3  MMU read func3.
REQ-020 SHALL have port: mmu_rd_valid  in  1  MMU read data valid.
REQ-021 SHALL have port: mmu_rd_data  in  32  MMU read data.
REQ-022 SHALL have port: mmu_wr_req  out  1  MMU write request pulse.
REQ-023 SHALL have port: mmu_wr_addr  out  32  MMU write address.
REQ-024 SHALL have port: mmu_wr_data  out  32  MMU write data.
REQ-025 SHALL have port: mmu_wr_func3  out  3  MMU write func3.
REQ-026 SHALL have port: mmu_wr_done  in  1  MMU write complete.
REQ-027 SHALL have port: timeout_err  out  1  sticky timeout flag.

Function
REQ-028 SHALL implement FSM IDLE, RD_WAIT, WR_WAIT; one MMU transaction outstanding max.
REQ-029 SHALL, in IDLE with one req high, grant it; both high: round-robin on last-granted bit (reset value = IF, so LS wins first tie).
REQ-030 SHALL register grant: decision cycle N -> during N+1 xx_gnt=1, mmu_rd_req or mmu_wr_req=1 for exactly one cycle, address/data/func3 latched and held stable until response.
REQ-031 SHALL drive mmu_rd_func3=3'b010 for fetch; ls_func3 passed through for loads/stores.
REQ-032 SHALL enter RD_WAIT for fetch or load, WR_WAIT for store; never assert mmu_rd_req and mmu_wr_req together.
REQ-033 SHALL ignore requester req while not in IDLE; a req still high in the gnt cycle is not a new request.
REQ-034 SHALL, on mmu_rd_valid sampled in RD_WAIT, pulse owner's valid one cycle later with rdata = captured mmu_rd_data, return to IDLE.
REQ-035 SHALL, on mmu_wr_done sampled in WR_WAIT, pulse ls_valid one cycle later with ls_rdata=0, return to IDLE.
REQ-036 SHALL ignore mmu_rd_valid/mmu_wr_done outside matching wait state.
REQ-037 SHALL count wait cycles in 8-bit counter cleared on wait entry; at count==TIMEOUT: owner valid pulse with rdata 0, timeout_err set, IDLE.
REQ-038 SHALL give response priority over timeout when both occur same cycle (no error).
REQ-039 SHALL allow next grant earliest one cycle after valid pulse (IDLE arbitration cycle).

Reset
REQ-040 SHALL, on rstn low, asynchronously clear all outputs, data/address registers, counter, timeout_err to 0, FSM to IDLE, last-granted to IF.
REQ-041 SHALL abandon an in-flight transaction on reset; late MMU responses after reset ignored.

Verification
REQ-042 SHALL verify: if_req, if_addr=0x100, mmu_rd_valid 3 cycles after mmu_rd_req with data 0xCAFE0001 -> if_gnt pulse, mmu_rd_addr=0x100, func3=010, if_valid one cycle later, if_rdata=0xCAFE0001.
REQ-043 SHALL verify: if_req and ls_req held high together -> grants alternate LS, IF, LS, IF.
REQ-044 SHALL verify: store ls_addr=0x200, ls_wdata=0x12345678, func3=010 -> one mmu_wr_req pulse with those values, ls_valid after mmu_wr_done, ls_rdata=0.
REQ-045 SHALL verify: TIMEOUT=8, no MMU response -> owner valid after 8 wait cycles, rdata 0, timeout_err=1 until reset.
REQ-046 SHALL verify: rstn low during RD_WAIT, then mmu_rd_valid after release -> no if_valid/ls_valid, FSM IDLE, all outputs 0.
REQ-047 SHALL verify: mmu_rd_valid asserted in IDLE or WR_WAIT -> no valid pulse, state unchanged.
